dc_motor_pwm_driver: RTL and testbench
======================================

// Module: dc_motor_pwm_driver
// PURPOSE
//   Converts the signed 16-bit velocity-loop control word into H-bridge PWM and direction signals.
//   Sits downstream of the PI velocity controller and drives the motor bridge pins directly.
//   Generates a fixed-frequency edge-aligned PWM with break-before-make dead time on reversal.
//   Exports a period strobe that the controller and encoder sampling can use as their tick.
// PARAMETERS
//   PWM_PERIOD  5000  clk cycles per PWM period (100 MHz / 5000 = 20 kHz)
//   DUTY_MAX    4000  duty clamp in clk cycles; must be < PWM_PERIOD
//   DEAD_TIME   100   cycles both legs held low at start of a period after reversal/enable
//   SLEW_STEP   200   max duty change per period; used only with DRIVER_SLEW_LIMIT_EN
// PORTS
//   clk           in   1   system clock, 100 MHz
//   reset         in   1   asynchronous, active-high reset
//   enable        in   1   bridge enable; low forces both legs off
//   cmd           in   16  signed duty command; + = forward, - = reverse
//   pwm_a         out  1   forward leg drive
//   pwm_b         out  1   reverse leg drive
//   dir           out  1   applied direction, 0 = forward, 1 = reverse
//   period_tick   out  1   one-cycle strobe when counter == PWM_PERIOD-1
//   duty_applied  out  13  duty magnitude used in the current period
//   sat           out  1   1 while |cmd| exceeded DUTY_MAX at last latch
// BEHAVIOUR
//   Reset: one clock; reset is asynchronous and active-high. All outputs 0, counter 0, state IDLE.
//   Counter counts 0..PWM_PERIOD-1 and wraps to 0. period_tick is registered high in the cycle counter == PWM_PERIOD-1.
//   Latch: cmd is sampled only at counter == PWM_PERIOD-1. mag = |cmd|; -32768 maps to 32768.
//     If mag > DUTY_MAX: duty = DUTY_MAX and sat = 1. Otherwise duty = mag and sat = 0.
//     New duty, dir and sat take effect from counter 0 of the next period. cmd changes mid-period are ignored.
//   FSM states: IDLE, DEAD, RUN. Transitions are evaluated at the period boundary unless noted.
//     IDLE -> DEAD: enable = 1 at the boundary.
//     RUN -> DEAD: latched sign differs from the current dir and duty != 0.
//     DEAD -> RUN: after DEAD_TIME cycles (counter == DEAD_TIME-1).
//     any -> IDLE: synchronously, the cycle after enable = 0, at any counter value.
//   Outputs:
//     IDLE: pwm_a = pwm_b = 0; counter and period_tick keep running.
//     DEAD: both legs 0 for counter < DEAD_TIME.
//     RUN: active leg = (counter < duty); inactive leg = 0.
//       Active leg is pwm_a when dir = 0 and pwm_b when dir = 1.
//     In a period that began in DEAD, the active leg is high for DEAD_TIME <= counter < duty.
//     pwm_a and pwm_b are registered: 1 cycle latency from counter. They are never 1 simultaneously.
//   Zero command: duty = 0, both legs low, dir holds its previous value and no DEAD is inserted.
//     A later nonzero command of the opposite sign does enter DEAD.
//   Simultaneous events: enable falling on the latch cycle wins and the state goes to IDLE.
//   Reset mid-period: legs drop low asynchronously and the counter restarts at 0.
// CONFIGURATION
//   DRIVER_SLEW_LIMIT_EN defined:
//     At each latch, duty_applied moves toward the target by at most SLEW_STEP per period.
//     On reversal, duty ramps from 0 after DEAD; sat still reflects the raw |cmd|.
//   DRIVER_SLEW_LIMIT_EN undefined: duty_applied jumps directly to the target. SLEW_STEP is unused.
// STRUCTURE
//   Package dc_motor_pkg holds:
//     - PWM_PERIOD, DUTY_MAX and DEAD_TIME defaults;
//     - the 13-bit duty width constant;
//     - the drv_state_t enum (IDLE, DEAD, RUN).
//   One sub-module, pwm_period_counter: wrap counter plus period_tick. It is shared with encoder sampling.
// TESTING
//   1. Assert reset, then release -> all outputs 0; period_tick pulses every 5000 cycles, first at cycle 4999.
//   2. enable = 1, cmd = +2000 -> first period is DEAD with pwm_a high for counter 100..1999;
//      subsequent periods pwm_a high 2000 cycles, pwm_b = 0, dir = 0.
//   3. Steady cmd = +2000, then cmd = -1000 -> next period has pwm_b high for counter 100..999 and dir = 1;
//      the following period has pwm_b high 1000 cycles; pwm_a stays 0 throughout.
//   4. cmd = -32768 -> pwm_b high 4000 cycles per period, sat = 1, duty_applied = 4000.
//   5. enable falls at counter 1500 with pwm_a high -> pwm_a = 0 by the next cycle;
//      re-enable -> DEAD period before RUN.
//   6. Reset asserted at counter 800 with duty 2000 -> pwm_a = 0 immediately, counter = 0, duty_applied = 0.
//      Also check with DRIVER_SLEW_LIMIT_EN: 0 -> +1000 ramps 200, 400, ... over 5 periods.

Source files
------------

// File: rtl/dc_motor_pkg.sv
// Shared constants, duty type and driver state enum for the DC motor PWM driver.
package dc_motor_pkg;

   localparam int PWM_PERIOD = 5000;
   localparam int DUTY_MAX   = 4000;
   localparam int DEAD_TIME  = 100;
   localparam int SLEW_STEP  = 200;
   localparam int DUTY_W     = 13;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      IDLE,
      DEAD,
      RUN
   } drv_state_t;

   // -32768 must map to +32768, hence the 17-bit result
   function automatic logic [16:0] cmd_mag(input logic signed [15:0] c);
      logic [16:0] e;
      e = {c[15], c};
      return c[15] ? (17'd0 - e) : e;
   endfunction

endpackage

// File: rtl/dc_motor_pwm_driver_if.sv
// Command and bridge-drive bundle between the velocity controller side and the driver.
interface dc_motor_pwm_driver_if;
   import dc_motor_pkg::*;

   logic               enable;
   logic signed [15:0] cmd;
   logic               pwm_a;
   logic               pwm_b;
   logic               dir;
   logic               period_tick;
   duty_t              duty_applied;
   logic               sat;

   modport master (
      output enable, cmd,
      input  pwm_a, pwm_b, dir, period_tick, duty_applied, sat
   );

   modport slave (
      input  enable, cmd,
      output pwm_a, pwm_b, dir, period_tick, duty_applied, sat
   );

endinterface

// File: rtl/pwm_period_counter.sv
// PWM period wrap counter with registered end-of-period strobe.
module pwm_period_counter #(
   parameter int PERIOD = dc_motor_pkg::PWM_PERIOD,
   localparam int CW = $clog2(PERIOD)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [CW-1:0] cnt,
   output logic          last,
   output logic          tick
);

   assign last = (cnt == CW'(PERIOD-1));

   // tick is registered one count early so it lines up with cnt == PERIOD-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= last ? '0 : cnt + CW'(1);
         tick <= (cnt == CW'(PERIOD-2));
      end
   end

endmodule

// File: rtl/dc_motor_pwm_driver.sv
// H-bridge PWM driver with dead time on reversal/enable.
// Optional duty slew limiting when DRIVER_SLEW_LIMIT_EN is defined.
module dc_motor_pwm_driver #(
   parameter int PWM_PERIOD = dc_motor_pkg::PWM_PERIOD,
   parameter int DUTY_MAX   = dc_motor_pkg::DUTY_MAX,
   parameter int DEAD_TIME  = dc_motor_pkg::DEAD_TIME
) (
   input logic                  clk,
   input logic                  reset,
   dc_motor_pwm_driver_if.slave bus
);
   import dc_motor_pkg::*;

   localparam int CW = $clog2(PWM_PERIOD);

   logic [CW-1:0] cnt;
   logic          last;
   logic          tick;

   pwm_period_counter #(.PERIOD(PWM_PERIOD)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .cnt   (cnt),
      .last  (last),
      .tick  (tick)
   );

   drv_state_t  state, state_nx;
   duty_t       duty, duty_nx, target;
   logic        dir, dir_nx, sat, sat_nx, rev;
   logic        pa, pb, pa_nx, pb_nx;
   logic [16:0] mag;

   always_comb begin
      mag    = cmd_mag(bus.cmd);
      sat_nx = (mag > 17'(DUTY_MAX));
      target = sat_nx ? DUTY_W'(DUTY_MAX) : mag[DUTY_W-1:0];
      dir_nx = (target != '0) ? bus.cmd[15] : dir;
      rev    = (target != '0) && (bus.cmd[15] != dir);
`ifdef DRIVER_SLEW_LIMIT_EN
      // a reversal restarts the ramp from zero
      if (rev)
         duty_nx = (target > DUTY_W'(SLEW_STEP)) ? DUTY_W'(SLEW_STEP) : target;
      else if (target > duty)
         duty_nx = (target - duty > DUTY_W'(SLEW_STEP)) ?
                   duty + DUTY_W'(SLEW_STEP) : target;
      else
         duty_nx = (duty - target > DUTY_W'(SLEW_STEP)) ?
                   duty - DUTY_W'(SLEW_STEP) : target;
`else
      duty_nx = target;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty <= '0;
         dir  <= 1'b0;
         sat  <= 1'b0;
      end else if (last) begin
         duty <= duty_nx;
         dir  <= dir_nx;
         sat  <= sat_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!bus.enable) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: if (last) state_nx = DEAD;
            DEAD: if (cnt == CW'(DEAD_TIME-1)) state_nx = RUN;
            RUN:  if (last && rev) state_nx = DEAD;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      pa_nx = 1'b0;
      pb_nx = 1'b0;
      if (bus.enable && state == RUN && (32'(cnt) < 32'(duty))) begin
         pa_nx = !dir;
         pb_nx = dir;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pa <= 1'b0;
         pb <= 1'b0;
      end else begin
         pa <= pa_nx;
         pb <= pb_nx;
      end
   end

   assign bus.pwm_a        = pa;
   assign bus.pwm_b        = pb;
   assign bus.dir          = dir;
   assign bus.period_tick  = tick;
   assign bus.duty_applied = duty;
   assign bus.sat          = sat;

endmodule

// File: tb/tb_dc_motor_pwm_driver.sv
// Scoreboard bench: per-period expected leg activity queued by stimulus, checked by monitor.
module tb_dc_motor_pwm_driver;
   import dc_motor_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;

   dc_motor_pwm_driver_if bus ();

   dc_motor_pwm_driver dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int na; int nb; int fa; int fb;
      int dir; int duty; int sat; int bad;
   } rec_t;

   rec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(string nm, int idx, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s period %0d: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   function automatic rec_t mk(int na, int nb, int fa, int fb,
                               int dir, int duty, int sat);
      rec_t r;
      r.na = na; r.nb = nb; r.fa = fa; r.fb = fb;
      r.dir = dir; r.duty = duty; r.sat = sat; r.bad = 0;
      return r;
   endfunction

   function automatic rec_t clr();
      return mk(0, 0, -1, -1, 0, 0, 0);
   endfunction

   task automatic score(rec_t a, int idx);
      rec_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_period %0d: got record, want none", idx);
      end else begin
         e = exp_q.pop_front();
         chk("pwm_a_cycles", idx, a.na, e.na);
         chk("pwm_b_cycles", idx, a.nb, e.nb);
         chk("pwm_a_first", idx, a.fa, e.fa);
         chk("pwm_b_first", idx, a.fb, e.fb);
         chk("dir", idx, a.dir, e.dir);
         chk("duty_applied", idx, a.duty, e.duty);
         chk("sat", idx, a.sat, e.sat);
         chk("leg_conflict", idx, a.bad, e.bad);
      end
   endtask

   // Monitor: a record closes on each period_tick, or early on reset
   initial begin : mon
      rec_t cur;
      int   c;
      bit   act;
      int   pidx;
      c = 0; act = 0; pidx = 0;
      cur = clr();
      forever begin
         @(negedge clk);
         if (reset) begin
            if (act) begin
               if (bus.pwm_a || bus.pwm_b) cur.bad = 1;
               cur.dir  = int'(bus.dir);
               cur.duty = int'(bus.duty_applied);
               cur.sat  = int'(bus.sat);
               score(cur, pidx);
               pidx++;
            end
            act = 0;
            c = 0;
            cur = clr();
         end else begin
            act = 1;
            if (bus.pwm_a) begin
               cur.na++;
               if (cur.fa < 0) cur.fa = c - 1;
            end
            if (bus.pwm_b) begin
               cur.nb++;
               if (cur.fb < 0) cur.fb = c - 1;
            end
            if (bus.pwm_a && bus.pwm_b) cur.bad = 1;
            if (bus.period_tick) begin
               chk("tick_position", pidx, c, PWM_PERIOD - 1);
               cur.dir  = int'(bus.dir);
               cur.duty = int'(bus.duty_applied);
               cur.sat  = int'(bus.sat);
               score(cur, pidx);
               pidx++;
               c = 0;
               cur = clr();
            end else begin
               c++;
            end
         end
      end
   end

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.period_tick && n < 6000);
      if (!bus.period_tick) begin
         n_cmp++;
         n_bad++;
         $display("FAIL tick_timeout: got none in %0d cycles, want 5000", n);
      end
   endtask

   // move to counter value k of the next period
   task automatic go_to(int k);
      wait_tick();
      repeat (k + 1) @(posedge clk);
      #2;
   endtask

   initial begin : watchdog
      #(10 * 95000);
      $display("FAIL watchdog: got no finish, want finish before 95000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.enable = 1'b0;
      bus.cmd    = '0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      exp_q.push_back(mk(0, 0, -1, -1, 0, 0, 0));
      repeat (1000) @(posedge clk);
      #2;
      bus.enable = 1'b1;
`ifdef DRIVER_SLEW_LIMIT_EN
      bus.cmd = 16'sd1000;
      exp_q.push_back(mk(100, 0, 100, -1, 0, 200, 0));
      exp_q.push_back(mk(400, 0, 0, -1, 0, 400, 0));
      exp_q.push_back(mk(600, 0, 0, -1, 0, 600, 0));
      exp_q.push_back(mk(800, 0, 0, -1, 0, 800, 0));
      exp_q.push_back(mk(1000, 0, 0, -1, 0, 1000, 0));
`else
      bus.cmd = 16'sd2000;
      exp_q.push_back(mk(1900, 0, 100, -1, 0, 2000, 0));
      go_to(2500);
      exp_q.push_back(mk(2000, 0, 0, -1, 0, 2000, 0));
      go_to(2500);
      bus.cmd = -16'sd1000;
      exp_q.push_back(mk(0, 900, -1, 100, 1, 1000, 0));
      go_to(2500);
      exp_q.push_back(mk(0, 1000, -1, 0, 1, 1000, 0));
      go_to(2500);
      bus.cmd = 16'h8000;
      exp_q.push_back(mk(0, 4000, -1, 0, 1, 4000, 1));
      go_to(2500);
      bus.cmd = '0;
      exp_q.push_back(mk(0, 0, -1, -1, 1, 0, 0));
      go_to(2500);
      bus.cmd = -16'sd500;
      exp_q.push_back(mk(0, 500, -1, 0, 1, 500, 0));
      go_to(2500);
      bus.cmd = 16'sd2000;
      exp_q.push_back(mk(1900, 0, 100, -1, 0, 2000, 0));
      go_to(2500);
      exp_q.push_back(mk(1500, 0, 0, -1, 0, 2000, 0));
      go_to(1500);
      bus.enable = 1'b0;
      exp_q.push_back(mk(0, 0, -1, -1, 0, 2000, 0));
      go_to(2500);
      bus.enable = 1'b1;
      exp_q.push_back(mk(1900, 0, 100, -1, 0, 2000, 0));
      go_to(2500);
      exp_q.push_back(mk(799, 0, 0, -1, 0, 0, 0));
      go_to(800);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      exp_q.push_back(mk(0, 0, -1, -1, 0, 0, 0));
      exp_q.push_back(mk(1900, 0, 100, -1, 0, 2000, 0));
`endif
      for (int i = 0; i < 12000 && exp_q.size() > 0; i++)
         @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending periods, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
